// File: rtl/mult_bcd_pkg.sv
// ============================================================================
// Module  : mult_bcd_pkg
// Purpose : Shared widths, step counts and FSM state type for mult_bcd_seq.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_bcd_pkg;
  localparam int OP_W       = 4;
  localparam int PROD_W     = 8;
  localparam int BCD_W      = 12;
  localparam int SHREG_W    = 20;
  localparam int MULT_STEPS = 4;
  localparam int CONV_STEPS = 8;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    CONV = 2'd2
  } state_e;
endpackage

`default_nettype wire

// File: rtl/dabble_step.sv
// ============================================================================
// Module  : dabble_step
// Purpose : One double-dabble iteration: +3 on BCD nibbles >= 5, then shift.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dabble_step
  import mult_bcd_pkg::*;
(
  input  logic [SHREG_W-1:0] din_i,
  output logic [SHREG_W-1:0] dout_o
);

  logic [SHREG_W-1:0] w_adj;

  assign w_adj[PROD_W-1:0] = din_i[PROD_W-1:0];

  // Adjustment is evaluated on the pre-shift value of each BCD digit
  generate
    for (genvar g = 0; g < 3; g++) begin : g_digit
      localparam int LSB = PROD_W + 4 * g;
      assign w_adj[LSB +: 4] = (din_i[LSB +: 4] >= 4'd5) ? din_i[LSB +: 4] + 4'd3
                                                         : din_i[LSB +: 4];
    end
  endgenerate

  assign dout_o = w_adj << 1;

endmodule

`default_nettype wire

// File: rtl/mult_bcd_seq.sv
// ============================================================================
// Module  : mult_bcd_seq
// Purpose : Time-shared 4x4 shift-add multiplier followed by binary-to-BCD.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_bcd_seq
  import mult_bcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product,
  output logic [BCD_W-1:0]  bcd
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0]  acc_q, acc_d, acc_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHREG_W-1:0] shreg_q, shreg_d, dab_out;
  logic               busy_q, busy_d, done_q, done_d;
  logic [PROD_W-1:0]  product_q, product_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  dabble_step u_dabble (
    .din_i  (shreg_q),
    .dout_o (dab_out)
  );

  assign acc_step = acc_q + (b_q[cnt_q[1:0]] ? ({4'b0, a_q} << cnt_q[1:0]) : 8'd0);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MULT;
        end
      end
      MULT: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MULT_STEPS - 1)) begin
          shreg_d = {12'b0, acc_step};
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        shreg_d = dab_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CONV_STEPS - 1)) begin
          bcd_d     = dab_out[SHREG_W-1:PROD_W];
          product_d = acc_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign bcd     = bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_bcd_seq.sv
// ============================================================================
// Module  : tb_mult_bcd_seq
// Purpose : Self-checking bench for mult_bcd_seq against a decimal model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        busy;
  logic        done;
  logic [7:0]  product;
  logic [11:0] bcd;

  int n_chk  = 0;
  int n_pass = 0;

  mult_bcd_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .bcd     (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic logic [11:0] ref_bcd(input int p);
    ref_bcd = 12'((p / 100) * 256 + ((p / 10) % 10) * 16 + (p % 10));
  endfunction

  // One-cycle start pulse, then wait for done; checks latency, busy span and result.
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input string tag);
    int lat;
    int bcnt;
    int p;
    p = int'(x) * int'(y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"},  lat, 12);
    check({tag, "_busy"}, bcnt, 12);
    check({tag, "_prod"}, product, p);
    check({tag, "_bcd"},  bcd, ref_bcd(p));
  endtask

  initial begin
    int k;
    int gap;
    int dcnt;
    int ia, ib;
    logic [7:0]  hp;
    logic [11:0] hb;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);
    check("rst_bcd",  bcd, 0);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("idle_nodone", dcnt, 0);
    check("idle_prod", product, 0);

    run_op(4'd15, 4'd15, "max");
    check("max_bcd_const", bcd, 12'h225);
    check("max_prod_const", product, 8'hE1);
    @(negedge clk);
    check("max_done_pulse", done, 0);

    // Back-to-back sweep with start held high continuously
    @(negedge clk);
    a = 4'd0; b = 4'd0; start = 1'b1;
    for (int idx = 0; idx < 256; idx++) begin
      ia = idx / 16; ib = idx % 16;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done && k < 30);
      check("sweep_period", k, 13);
      check("sweep_prod", product, ia * ib);
      check("sweep_bcd",  bcd, ref_bcd(ia * ib));
      if (ia == 9 && ib == 9)  check("spot_9x9",   bcd, 12'h081);
      if (ia == 12 && ib == 10) check("spot_12x10", bcd, 12'h120);
      if (ia == 0 && ib == 7)  check("spot_0x7",   bcd, 12'h000);
      if (idx < 255) begin
        a = 4'((idx + 1) / 16);
        b = 4'((idx + 1) % 16);
      end else begin
        start = 1'b0;
      end
    end
    repeat (15) @(negedge clk);

    // Start while busy is ignored
    @(negedge clk);
    a = 4'd3; b = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 4'd9; b = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        check("busy_ign_bcd", bcd, 12'h012);
      end
    end
    check("busy_ign_count", dcnt, 1);
    check("busy_ign_prod", product, 12);

    // Reset mid-CONV
    @(negedge clk);
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_prod", product, 0);
    check("mrst_bcd",  bcd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("mrst_no_stale", dcnt, 0);
    run_op(4'd7, 4'd8, "post_rst");
    check("post_rst_const", bcd, 12'h056);

    // Hold after done
    run_op(4'd6, 4'd7, "hold");
    hp = product; hb = bcd;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom); b = 4'($urandom);
      @(negedge clk);
      if (done) dcnt++;
    end
    check("hold_prod", product, 8'd42);
    check("hold_bcd",  bcd, 12'h042);
    check("hold_same", {hp, hb}, {product, bcd});
    check("hold_nodone", dcnt, 0);

    // Randomized operands with random idle gaps
    for (int i = 0; i < 24; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      run_op(4'($urandom), 4'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mult_bcd_seq.md
# mult_bcd_seq

Multi-cycle sequencer for the 4x4 multiplier display path. It accepts two 4-bit operands on a start pulse, forms the 8-bit product by iterative shift-add (one partial product per cycle), then converts it to 3-digit BCD by iterative shift-add-3 (one bit per cycle), and presents a registered result with a done pulse. It sits between the operand switches/latch and the 7-segment digit decoder/scanner. It replaces the fully unrolled combinational conversion with a small, fixed-latency, time-shared datapath.

## Interface
Parameters: none; widths are fixed, with constants in the package.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  4  multiplicand, captured on accepted start
- b  in  4  multiplier, captured on accepted start
- busy  out  1  high from the accepting edge through the last CONV edge
- done  out  1  one-cycle pulse; result valid
- product  out  8  registered binary product, updated with done
- bcd  out  12  registered BCD {hundreds, tens, ones}, updated with done

## Operation
- States are IDLE, MULT, CONV.
- IDLE:
  - start=1 at an edge latches a and b.
  - Clears acc[7:0] and the 3-bit cnt.
  - Moves to MULT.
- MULT, one edge per bit i=cnt (0..3):
  - If b_q[i], acc += a_q << i.
  - cnt++.
  - At the edge with cnt==3, loads shreg[19:0] = {12'b0, acc_next}, clears cnt and moves to CONV.
- CONV, one edge per iteration (cnt 0..7):
  - Each nibble shreg[11:8], [15:12] and [19:16] that is >=5 gets +3, evaluated on the pre-shift value.
  - The whole register then shifts left by 1, and cnt++.
  - At the edge with cnt==7:
    - bcd <= shifted[19:8] and product <= acc.
    - done <= 1 and busy <= 0.
    - State moves to IDLE.
- done is high for exactly one cycle. bcd and product hold until the next completion.
- start while busy is ignored: no queueing and no restart. Operands a and b may change freely after acceptance.
- start during the done cycle is in IDLE, so it is accepted at that edge. done and busy are both high in the following cycle? No: done drops and busy rises. Back-to-back throughput is one result per 13 cycles.
- Arithmetic:
  - acc is 8-bit. The maximum 15*15=225 fits, and no overflow is possible.
  - The add-3 nibble math is 4-bit. Values >=5 only occur before the shift, so the result stays <=15.
  - The hundreds digit never exceeds 2.
- Reset at any time, including mid-MULT or mid-CONV, forces:
  - state=IDLE, busy=0, done=0.
  - product=8'h00, bcd=12'h000.
  - acc, shreg, cnt, a_q and b_q all cleared.
- There is no partial output after reset.

## Timing
- Reset values: busy=0, done=0, product=0, bcd=0.
- Schedule, where E0 is the accepting edge:
  - E1..E4 are MULT.
  - E5..E12 are CONV.
  - done is high between E12 and E13.
- Latency is 12 cycles from the accepting edge to done high.
- busy is high between E0 and E12, and low once done is high.
- All outputs are registers. There are no combinational paths from inputs to outputs.

## Structure
- Package mult_bcd_pkg holds:
  - state enum {IDLE, MULT, CONV}.
  - OP_W=4, PROD_W=8, BCD_W=12, SHREG_W=20.
  - MULT_STEPS=4, CONV_STEPS=8.
- Sub-module dabble_step is combinational, 20-bit in and 20-bit out. It applies conditional +3 to the three BCD nibbles, then shifts left 1. The FSM instantiates it once.
- The multiply step stays inline in the FSM: one conditional add.

## Test plan
- Reset/idle check:
  - Hold rst_n=0, then release.
  - Required: busy=0, done=0, product=0x00, bcd=0x000, with no done pulse for 20 idle cycles.
- Maximum operands:
  - a=15, b=15, start one cycle.
  - Required: done exactly 12 cycles after acceptance, product=0xE1, bcd=0x225, and busy high for exactly 12 cycles.
- Sweep plus boundary values:
  - Run all 256 (a,b) pairs back-to-back, with start held high continuously.
  - Required: each product is a*b and each bcd is its decimal value, one result every 13 cycles.
  - Spot checks: 9*9 gives 0x081, 12*10 gives 0x120, 0*7 gives 0x000.
- Start while busy:
  - a=3, b=4, start, then pulse start with a=9, b=9 at cycle 5.
  - Required: a single done with bcd=0x012. The second start is ignored.
- Reset mid-CONV:
  - Start 15*15, then assert rst_n=0 at cycle 8.
  - Required: outputs are zero immediately. After release, a new start 7*8 yields bcd=0x056 with no stale data.
- Hold after done:
  - After 6*7 completes (bcd=0x042), change a and b with no start.
  - Required: bcd and product stay unchanged and done stays low.
